// File: rtl/xentry_types.sv
// Shared types for the cache-to-L2 request path.
package xentry_types;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } l2_owner_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IC = 2'd1,
    ST_GRANT_DC = 2'd2
  } l2_arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; bit 0 = icache, bit 1 = dcache.
// The last-owner register only moves on the update strobe.
module rr_arbiter2
  import xentry_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic [1:0] i_req,
  input  logic      i_update,
  output logic [1:0] o_gnt,
  output l2_owner_e o_last_owner
);

  l2_owner_e r_last_owner;

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last_owner == OWN_IC) ? 2'b10 : 2'b01;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_IC;
    end else if (i_update && (o_gnt != '0)) begin
      r_last_owner <= o_gnt[1] ? OWN_DC : OWN_IC;
    end
  end

  assign o_last_owner = r_last_owner;

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares one L2 request port between icache and dcache, locking the grant
// for a whole line burst and alternating owners when both are waiting.
module l2_request_arbiter
  import xentry_types::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BEATS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  memory_operation_e ic_req_type,
  input  logic [XLEN-1:0]   ic_req_addr,
  output logic              ic_req_fulfilled,
  output logic [XLEN-1:0]   ic_rdata,
  input  logic              dc_req_valid,
  input  memory_operation_e dc_req_type,
  input  logic [XLEN-1:0]   dc_req_addr,
  input  logic [XLEN-1:0]   dc_req_wdata,
  output logic              dc_req_fulfilled,
  output logic [XLEN-1:0]   dc_rdata,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [XLEN-1:0]   l2_req_addr,
  output logic [XLEN-1:0]   l2_req_wdata,
  input  logic              l2_req_fulfilled,
  input  logic [XLEN-1:0]   l2_rdata,
  output l2_owner_e         grant_owner
);

  localparam int unsigned CNT_W = $clog2(BEATS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);

  l2_arb_state_e    r_state;
  l2_arb_state_e    w_next_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [1:0]       w_gnt;
  logic             w_grant_stb;
  logic             w_beat_dec;

  // Arbitration happens only in idle, so the picker sees a strobe once per burst.
  assign w_grant_stb = (r_state == ST_IDLE) && (ic_req_valid || dc_req_valid);

  rr_arbiter2 u_rr (
    .clk          (clk),
    .rst_n        (reset),
    .i_req        ({dc_req_valid, ic_req_valid}),
    .i_update     (w_grant_stb),
    .o_gnt        (w_gnt),
    .o_last_owner (grant_owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_stb) begin
        r_beat_cnt <= LAST_BEAT;
      end else if (w_beat_dec) begin
        r_beat_cnt <= r_beat_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_beat_dec       = 1'b0;
    l2_req_valid     = 1'b0;
    l2_req_type      = LOAD;
    l2_req_addr      = '0;
    l2_req_wdata     = '0;
    ic_req_fulfilled = 1'b0;
    dc_req_fulfilled = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt[1]) begin
          w_next_state = ST_GRANT_DC;
        end else if (w_gnt[0]) begin
          w_next_state = ST_GRANT_IC;
        end
      end
      ST_GRANT_IC: begin
        l2_req_valid     = ic_req_valid;
        l2_req_type      = ic_req_type;
        l2_req_addr      = ic_req_addr;
        ic_req_fulfilled = l2_req_fulfilled & ic_req_valid;
        if (!ic_req_valid) begin
          w_next_state = ST_IDLE;
        end else if (l2_req_fulfilled) begin
          if (r_beat_cnt == '0) w_next_state = ST_IDLE;
          else                  w_beat_dec   = 1'b1;
        end
      end
      ST_GRANT_DC: begin
        l2_req_valid     = dc_req_valid;
        l2_req_type      = dc_req_type;
        l2_req_addr      = dc_req_addr;
        l2_req_wdata     = dc_req_wdata;
        dc_req_fulfilled = l2_req_fulfilled & dc_req_valid;
        if (!dc_req_valid) begin
          w_next_state = ST_IDLE;
        end else if (l2_req_fulfilled) begin
          if (r_beat_cnt == '0) w_next_state = ST_IDLE;
          else                  w_beat_dec   = 1'b1;
        end
      end
      default: begin
        w_next_state     = l2_arb_state_e'('x);
        w_beat_dec       = 1'bx;
        l2_req_valid     = 1'bx;
        l2_req_type      = memory_operation_e'('x);
        l2_req_addr      = 'x;
        l2_req_wdata     = 'x;
        ic_req_fulfilled = 1'bx;
        dc_req_fulfilled = 1'bx;
      end
    endcase
  end

  assign ic_rdata = l2_rdata;
  assign dc_rdata = l2_rdata;

  // A beat completion with no owner is dropped; flag it without stopping the run.
  a_no_idle_fulfil: assert property (@(posedge clk) disable iff (!reset)
    !((r_state == ST_IDLE) && l2_req_fulfilled))
    else $warning("l2_req_fulfilled seen while idle; beat dropped");

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: requester and L2 models driven
// from a per-cycle stepping task, with expectations written as constants.
module tb_l2_request_arbiter;
  import xentry_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ic_req_valid;
  memory_operation_e ic_req_type;
  logic [31:0]       ic_req_addr;
  logic              ic_req_fulfilled;
  logic [31:0]       ic_rdata;
  logic              dc_req_valid;
  memory_operation_e dc_req_type;
  logic [31:0]       dc_req_addr;
  logic [31:0]       dc_req_wdata;
  logic              dc_req_fulfilled;
  logic [31:0]       dc_rdata;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [31:0]       l2_req_addr;
  logic [31:0]       l2_req_wdata;
  logic              l2_req_fulfilled;
  logic [31:0]       l2_rdata;
  l2_owner_e         grant_owner;

  // L2 backing store: each word is its address XOR a fixed pattern.
  assign l2_rdata = l2_req_addr ^ 32'hC0DE_0000;

  l2_request_arbiter #(.XLEN(32), .BEATS_PER_LINE(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ic_req_valid     (ic_req_valid),
    .ic_req_type      (ic_req_type),
    .ic_req_addr      (ic_req_addr),
    .ic_req_fulfilled (ic_req_fulfilled),
    .ic_rdata         (ic_rdata),
    .dc_req_valid     (dc_req_valid),
    .dc_req_type      (dc_req_type),
    .dc_req_addr      (dc_req_addr),
    .dc_req_wdata     (dc_req_wdata),
    .dc_req_fulfilled (dc_req_fulfilled),
    .dc_rdata         (dc_rdata),
    .l2_req_valid     (l2_req_valid),
    .l2_req_type      (l2_req_type),
    .l2_req_addr      (l2_req_addr),
    .l2_req_wdata     (l2_req_wdata),
    .l2_req_fulfilled (l2_req_fulfilled),
    .l2_rdata         (l2_rdata),
    .grant_owner      (grant_owner)
  );

  typedef struct {
    logic              is_ic;
    logic              is_dc;
    memory_operation_e op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
  } beat_t;

  beat_t       log_q[$];
  int          vec = 0;
  int          miss = 0;
  int          ic_beat, dc_beat, ic_bursts, dc_bursts, gapc, l2_gap;
  bit          l2_auto, p_ic, p_dc;
  logic [31:0] ic_base, dc_base, dc_wbase;

  // One cycle: retire last cycle's beats, drive requesters, then L2, then log.
  task automatic cyc();
    beat_t b;
    @(negedge clk);
    l2_req_fulfilled = 1'b0;
    if (p_ic) begin
      ic_beat++;
      if (ic_beat == 4) begin ic_req_valid = 1'b0; ic_bursts++; end
    end
    if (p_dc) begin
      dc_beat++;
      if (dc_beat == 4) begin dc_req_valid = 1'b0; dc_bursts++; end
    end
    p_ic = 1'b0;
    p_dc = 1'b0;
    ic_req_addr  = ic_base + 32'(ic_beat);
    dc_req_addr  = dc_base + 32'(dc_beat);
    dc_req_wdata = dc_wbase + 32'(dc_beat);
    #1;
    if (l2_auto && l2_req_valid) begin
      gapc++;
      if (gapc >= l2_gap) begin l2_req_fulfilled = 1'b1; gapc = 0; end
    end else begin
      gapc = 0;
    end
    #1;
    p_ic = ic_req_fulfilled;
    p_dc = dc_req_fulfilled;
    if (l2_req_fulfilled) begin
      b.is_ic = p_ic;
      b.is_dc = p_dc;
      b.op    = l2_req_type;
      b.addr  = l2_req_addr;
      b.wdata = l2_req_wdata;
      b.rdata = p_ic ? ic_rdata : dc_rdata;
      log_q.push_back(b);
    end
  endtask

  task automatic start_ic(input logic [31:0] base);
    ic_base = base; ic_beat = 0; ic_req_addr = base;
    ic_req_type = LOAD; ic_req_valid = 1'b1;
  endtask

  task automatic start_dc(input memory_operation_e op, input logic [31:0] base, input logic [31:0] wbase);
    dc_base = base; dc_wbase = wbase; dc_beat = 0;
    dc_req_addr = base; dc_req_wdata = wbase;
    dc_req_type = op; dc_req_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ic_req_valid = 1'b0; ic_req_type = LOAD; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_type = LOAD; dc_req_addr = '0; dc_req_wdata = '0;
    l2_req_fulfilled = 1'b0;
    ic_beat = 0; dc_beat = 0; ic_bursts = 0; dc_bursts = 0; gapc = 0;
    ic_base = '0; dc_base = '0; dc_wbase = '0;
    l2_gap = 1; l2_auto = 1'b1; p_ic = 1'b0; p_dc = 1'b0;
    log_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_type = LOAD; ic_req_addr = 32'h55;
    dc_req_valid = 1'b1; dc_req_type = STORE; dc_req_addr = 32'h123; dc_req_wdata = 32'hFFFF;
    l2_req_fulfilled = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vec++; if (l2_req_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b exp 0", l2_req_valid); end
    vec++; if (l2_req_type !== LOAD) begin miss++; $display("FAIL reset_type got %0d exp 0", l2_req_type); end
    vec++; if (l2_req_addr !== 32'h0) begin miss++; $display("FAIL reset_addr got %h exp 0", l2_req_addr); end
    vec++; if (l2_req_wdata !== 32'h0) begin miss++; $display("FAIL reset_wdata got %h exp 0", l2_req_wdata); end
    vec++; if (ic_req_fulfilled !== 1'b0 || dc_req_fulfilled !== 1'b0) begin
      miss++; $display("FAIL reset_fulfilled got ic=%b dc=%b exp 0 0", ic_req_fulfilled, dc_req_fulfilled);
    end
    vec++; if (grant_owner !== OWN_IC) begin miss++; $display("FAIL reset_owner got %0d exp OWN_IC", grant_owner); end
  endtask

  task automatic test_dc_store_alone();
    do_reset();
    l2_gap = 2;
    start_dc(STORE, 32'h100, 32'hA0);
    #1;
    vec++; if (l2_req_valid !== 1'b0) begin miss++; $display("FAIL t1_pre_grant_valid got %b exp 0", l2_req_valid); end
    cyc();
    vec++; if (l2_req_valid !== 1'b1 || l2_req_type !== STORE || l2_req_addr !== 32'h100 || grant_owner !== OWN_DC) begin
      miss++; $display("FAIL t1_first_req got v=%b t=%0d a=%h o=%0d exp 1 STORE 100 DC",
                       l2_req_valid, l2_req_type, l2_req_addr, grant_owner);
    end
    for (int i = 0; i < 40 && dc_bursts == 0; i++) cyc();
    vec++; if (dc_bursts != 1) begin miss++; $display("FAIL t1_timeout got bursts=%0d exp 1", dc_bursts); end
    vec++; if (l2_req_valid !== 1'b0 || log_q.size() != 4) begin
      miss++; $display("FAIL t1_end got v=%b beats=%0d exp 0 4", l2_req_valid, log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      vec++;
      if (log_q[i].is_dc !== 1'b1 || log_q[i].addr !== 32'h100 + 32'(i) || log_q[i].wdata !== 32'hA0 + 32'(i)) begin
        miss++; $display("FAIL t1_beat%0d got dc=%b a=%h w=%h exp 1 %h %h", i, log_q[i].is_dc,
                         log_q[i].addr, log_q[i].wdata, 32'h100 + 32'(i), 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_tie_both();
    logic [31:0] dbase, ibase, ea, ew;
    logic        edc;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      dbase = (r == 0) ? 32'h300 : 32'h340;
      ibase = (r == 0) ? 32'h200 : 32'h240;
      log_q.delete();
      start_dc(LOAD, dbase, 32'h77);
      start_ic(ibase);
      for (int i = 0; i < 60 && ic_bursts == r; i++) cyc();
      vec++; if (ic_bursts != r + 1 || log_q.size() != 8) begin
        miss++; $display("FAIL t2_round%0d_done got ic_bursts=%0d beats=%0d exp %0d 8", r, ic_bursts, log_q.size(), r + 1);
      end
      for (int i = 0; i < 8 && i < log_q.size(); i++) begin
        edc = (i < 4);
        ea  = edc ? dbase + 32'(i) : ibase + 32'(i - 4);
        ew  = edc ? 32'h77 + 32'(i) : 32'h0;
        vec++;
        if (log_q[i].is_dc !== edc || log_q[i].is_ic !== !edc || log_q[i].addr !== ea || log_q[i].wdata !== ew) begin
          miss++; $display("FAIL t2_r%0d_beat%0d got dc=%b ic=%b a=%h w=%h exp dc=%b a=%h w=%h", r, i,
                           log_q[i].is_dc, log_q[i].is_ic, log_q[i].addr, log_q[i].wdata, edc, ea, ew);
        end
      end
    end
  endtask

  task automatic test_ic_midburst();
    int bad = 0;
    do_reset();
    l2_gap = 2;
    start_dc(LOAD, 32'h400, 32'h0);
    for (int i = 0; i < 20 && dc_beat < 1; i++) cyc();
    vec++; if (dc_beat != 1) begin miss++; $display("FAIL t3_beat1_timeout got %0d exp 1", dc_beat); end
    start_ic(32'h500);
    for (int i = 0; i < 40 && dc_bursts == 0; i++) begin
      cyc();
      if (dc_bursts == 0 && (l2_req_valid !== 1'b1 || l2_req_addr !== dc_req_addr ||
                             l2_req_type !== LOAD || grant_owner !== OWN_DC)) bad++;
    end
    vec++; if (dc_bursts != 1 || bad != 0) begin
      miss++; $display("FAIL t3_dc_locked got bursts=%0d bad_cycles=%0d exp 1 0", dc_bursts, bad);
    end
    vec++; if (l2_req_valid !== 1'b0) begin miss++; $display("FAIL t3_idle_gap got v=%b exp 0", l2_req_valid); end
    cyc();
    vec++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 32'h500 || grant_owner !== OWN_IC) begin
      miss++; $display("FAIL t3_ic_grant got v=%b a=%h o=%0d exp 1 500 IC", l2_req_valid, l2_req_addr, grant_owner);
    end
    for (int i = 0; i < 20 && ic_bursts == 0; i++) cyc();
    vec++; if (ic_bursts != 1) begin miss++; $display("FAIL t3_ic_timeout got %0d exp 1", ic_bursts); end
  endtask

  task automatic test_wb_alloc_pair();
    logic              edc;
    memory_operation_e eop;
    logic [31:0]       ea, ew, er;
    int                seg, k;
    do_reset();
    start_dc(STORE, 32'h600, 32'hB0);
    start_ic(32'h700);
    for (int i = 0; i < 30 && dc_bursts == 0; i++) cyc();
    vec++; if (dc_bursts != 1) begin miss++; $display("FAIL t4_store_timeout got %0d exp 1", dc_bursts); end
    start_dc(LOAD, 32'h800, 32'h0);
    for (int i = 0; i < 60 && dc_bursts < 2; i++) cyc();
    vec++; if (dc_bursts != 2 || ic_bursts != 1 || log_q.size() != 12) begin
      miss++; $display("FAIL t4_done got dc=%0d ic=%0d beats=%0d exp 2 1 12", dc_bursts, ic_bursts, log_q.size());
    end
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      seg = i / 4;
      k   = i % 4;
      edc = (seg != 1);
      eop = (seg == 0) ? STORE : LOAD;
      ea  = (seg == 0) ? 32'h600 + 32'(k) : (seg == 1) ? 32'h700 + 32'(k) : 32'h800 + 32'(k);
      ew  = (seg == 0) ? 32'hB0 + 32'(k) : (seg == 1) ? 32'h0 : 32'(k);
      er  = (seg == 1) ? 32'hC0DE_0700 + 32'(k) : 32'hC0DE_0800 + 32'(k);
      vec++;
      if (log_q[i].is_dc !== edc || log_q[i].is_ic !== !edc || log_q[i].op !== eop ||
          log_q[i].addr !== ea || log_q[i].wdata !== ew || (seg != 0 && log_q[i].rdata !== er)) begin
        miss++; $display("FAIL t4_beat%0d got dc=%b op=%0d a=%h w=%h r=%h exp dc=%b op=%0d a=%h w=%h r=%h", i,
                         log_q[i].is_dc, log_q[i].op, log_q[i].addr, log_q[i].wdata, log_q[i].rdata,
                         edc, eop, ea, ew, er);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_dc(LOAD, 32'h900, 32'h0);
    for (int i = 0; i < 20 && dc_beat < 2; i++) cyc();
    vec++; if (dc_beat != 2) begin miss++; $display("FAIL t5_beat2_timeout got %0d exp 2", dc_beat); end
    #1 reset = 1'b0;
    #1;
    vec++; if (l2_req_valid !== 1'b0 || dc_req_fulfilled !== 1'b0 || grant_owner !== OWN_IC) begin
      miss++; $display("FAIL t5_async got v=%b f=%b o=%0d exp 0 0 IC", l2_req_valid, dc_req_fulfilled, grant_owner);
    end
    l2_req_fulfilled = 1'b0; dc_req_valid = 1'b0; p_dc = 1'b0; gapc = 0;
    dc_beat = 0; dc_bursts = 0;
    log_q.delete();
    @(negedge clk);
    reset = 1'b1;
    start_dc(LOAD, 32'h900, 32'h0);
    for (int i = 0; i < 30 && dc_bursts == 0; i++) cyc();
    vec++; if (dc_bursts != 1 || log_q.size() != 4) begin
      miss++; $display("FAIL t5_rerequest got bursts=%0d beats=%0d exp 1 4", dc_bursts, log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      vec++;
      if (log_q[i].is_dc !== 1'b1 || log_q[i].addr !== 32'h900 + 32'(i)) begin
        miss++; $display("FAIL t5_beat%0d got dc=%b a=%h exp 1 %h", i, log_q[i].is_dc, log_q[i].addr, 32'h900 + 32'(i));
      end
    end
  endtask

  task automatic test_idle_pulse_and_drop();
    do_reset();
    l2_auto = 1'b0;
    #1;
    start_dc(LOAD, 32'hA00, 32'h0);
    l2_req_fulfilled = 1'b1;
    #1;
    vec++; if (ic_req_fulfilled !== 1'b0 || dc_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0) begin
      miss++; $display("FAIL t6_idle_pulse got ic=%b dc=%b v=%b exp 0 0 0", ic_req_fulfilled, dc_req_fulfilled, l2_req_valid);
    end
    l2_auto = 1'b1;
    for (int i = 0; i < 20 && dc_beat < 1; i++) cyc();
    vec++; if (dc_beat != 1) begin miss++; $display("FAIL t6_beat1_timeout got %0d exp 1", dc_beat); end
    dc_req_valid = 1'b0;
    p_dc = 1'b0;
    start_ic(32'hB00);
    #1;
    vec++; if (dc_req_fulfilled !== 1'b0 || ic_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0) begin
      miss++; $display("FAIL t6_drop got dc=%b ic=%b v=%b exp 0 0 0", dc_req_fulfilled, ic_req_fulfilled, l2_req_valid);
    end
    log_q.delete();
    cyc();
    vec++; if (l2_req_valid !== 1'b0 || grant_owner !== OWN_DC) begin
      miss++; $display("FAIL t6_idle_after_drop got v=%b o=%0d exp 0 DC", l2_req_valid, grant_owner);
    end
    cyc();
    vec++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 32'hB00 || grant_owner !== OWN_IC) begin
      miss++; $display("FAIL t6_ic_grant got v=%b a=%h o=%0d exp 1 B00 IC", l2_req_valid, l2_req_addr, grant_owner);
    end
    for (int i = 0; i < 20 && ic_bursts == 0; i++) cyc();
    vec++; if (ic_bursts != 1 || log_q.size() != 4) begin
      miss++; $display("FAIL t6_ic_burst got bursts=%0d beats=%0d exp 1 4", ic_bursts, log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      vec++;
      if (log_q[i].is_ic !== 1'b1 || log_q[i].addr !== 32'hB00 + 32'(i) || log_q[i].rdata !== 32'hC0DE_0B00 + 32'(i)) begin
        miss++; $display("FAIL t6_beat%0d got ic=%b a=%h r=%h exp 1 %h %h", i, log_q[i].is_ic, log_q[i].addr,
                         log_q[i].rdata, 32'hB00 + 32'(i), 32'hC0DE_0B00 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc_store_alone();
    test_tie_both();
    test_ic_midburst();
    test_wb_alloc_pair();
    test_async_reset();
    test_idle_pulse_and_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
